// File: rtl/adder_tree_csa_pkg.sv
// Shared definitions for the adder_tree_csa_4_in tree and its response checker.
// The tree and the checker both size their output word with stage_count(), so
// their O_DATA_W values always agree.
package adder_tree_csa_pkg;

   // Number of carry-save reduction levels the tree spends on i_num operands
   // beyond its first pairwise level. The final carry-propagate add and the CSA
   // carry-out account for the two extra guard bits that callers add.
   function automatic int stage_count(input int i_num);
      if (i_num <= 2) begin
         return 0;
      end
      return $clog2(i_num) - 1;
   endfunction

   // Checker sequencing: wait for a launch, sum and wait for the tree, compare.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CMP  = 2'd2
   } chk_state_t;

endpackage

// File: rtl/adder_tree_csa_checker_sat_counter.sv
// Saturating up-counter used for the checker's pass and fail tallies.
// Once it reaches all-ones it holds there and never wraps.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;

   // Count one per inc pulse, sticking at the maximum value.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with <= so every flop samples the
      // pre-edge values, independent of statement order.
      if (rst) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/adder_tree_csa_checker.sv
// Response checker for the adder_tree_csa_4_in pipelined carry-save adder tree.
// On every accepted launch it sums the vector one word per cycle, samples the
// tree output LATENCY cycles after launch, and reports match/mismatch through
// o_done/o_err and two saturating counters.
// Optional build macro: ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN adds a snapshot of
// the first mismatching vector and the tree value that was received for it.
module adder_tree_csa_checker
   import adder_tree_csa_pkg::*;
#(
   parameter  int I_DATA_W = 3,
   parameter  int I_DATA_N = 4,
   parameter  int LATENCY  = 3,
   parameter  int CNT_W    = 16,
   localparam int O_DATA_W = I_DATA_W + stage_count(I_DATA_N) + 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_valid,
   input  logic [0:I_DATA_N-1][I_DATA_W-1:0]  i_data,
   input  logic [O_DATA_W-1:0]                i_tree_data,
   output logic                               o_busy,
   output logic                               o_done,
   output logic                               o_err,
   output logic [O_DATA_W-1:0]                o_expected,
   output logic [CNT_W-1:0]                   o_pass_cnt,
   output logic [CNT_W-1:0]                   o_fail_cnt,
   output logic                               o_overrun
`ifdef ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN
  ,output logic [0:I_DATA_N-1][I_DATA_W-1:0]  o_first_err_vec
  ,output logic [O_DATA_W-1:0]                o_first_err_got
  ,output logic                               o_first_err_vld
`endif
);

   localparam int IDX_W = (I_DATA_N > 1) ? $clog2(I_DATA_N) : 1;
   localparam int LAT_W = $clog2(LATENCY + 1);
   localparam int EXT_W = O_DATA_W - I_DATA_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(I_DATA_N - 1);
   localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(LATENCY);

   generate
      if (LATENCY < 1) begin : g_bad_latency
         $error("adder_tree_csa_checker: LATENCY must be >= 1");
      end
   endgenerate

   chk_state_t                          state_q,    state_d;
   logic [0:I_DATA_N-1][I_DATA_W-1:0]   vec_q,      vec_d;
   logic [O_DATA_W-1:0]                 acc_q,      acc_d;
   logic [IDX_W-1:0]                    idx_q,      idx_d;
   logic [LAT_W-1:0]                    lat_cnt_q,  lat_cnt_d;
   logic [O_DATA_W-1:0]                 tree_q,     tree_d;
   logic                                tree_ok_q,  tree_ok_d;
   logic                                sum_ok_q,   sum_ok_d;
   logic                                busy_q,     busy_d;
   logic                                done_q,     done_d;
   logic                                err_q,      err_d;
   logic [O_DATA_W-1:0]                 expected_q, expected_d;
   logic                                overrun_q,  overrun_d;
`ifdef ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN
   logic [0:I_DATA_N-1][I_DATA_W-1:0]   fe_vec_q,   fe_vec_d;
   logic [O_DATA_W-1:0]                 fe_got_q,   fe_got_d;
   logic                                fe_vld_q,   fe_vld_d;
`endif

   logic                                pass_inc;
   logic                                fail_inc;
   logic                                finish;
   logic                                mismatch;
   logic [O_DATA_W-1:0]                 word_ext;

   // Both halves of the check are complete: result goes out on this edge.
   assign finish   = (state_q == RUN) && sum_ok_q && tree_ok_q;
   assign mismatch = (acc_q != tree_q);
   assign word_ext = {{EXT_W{1'b0}}, vec_q[idx_q]};

   // Next-state and result computation for the launch/sum/compare sequence.
   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case/if tree leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      vec_d      = vec_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      lat_cnt_d  = lat_cnt_q;
      tree_d     = tree_q;
      tree_ok_d  = tree_ok_q;
      sum_ok_d   = sum_ok_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      expected_d = expected_q;
      overrun_d  = overrun_q;
      pass_inc   = 1'b0;
      fail_inc   = 1'b0;
`ifdef ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN
      fe_vec_d   = fe_vec_q;
      fe_got_d   = fe_got_q;
      fe_vld_d   = fe_vld_q;
`endif

      // A launch attempt outside IDLE is dropped but remembered.
      if (i_valid && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               vec_d     = i_data;
               acc_d     = '0;
               idx_d     = '0;
               lat_cnt_d = LAT_W'(1);
               tree_ok_d = 1'b0;
               sum_ok_d  = 1'b0;
               busy_d    = 1'b1;
               state_d   = RUN;
            end
         end

         RUN: begin
            if (finish) begin
               done_d     = 1'b1;
               err_d      = mismatch;
               expected_d = acc_q;
               busy_d     = 1'b0;
               pass_inc   = !mismatch;
               fail_inc   = mismatch;
               state_d    = CMP;
`ifdef ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN
               if (mismatch && !fe_vld_q) begin
                  fe_vec_d = vec_q;
                  fe_got_d = tree_q;
                  fe_vld_d = 1'b1;
               end
`endif
            end else begin
               // Serial reference sum, one word per edge.
               if (!sum_ok_q) begin
                  acc_d = acc_q + word_ext;
                  if (idx_q == LAST_IDX) begin
                     sum_ok_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
               // Tree output is sampled exactly LATENCY edges after launch.
               if (!tree_ok_q) begin
                  if (lat_cnt_q == LAT_END) begin
                     tree_d    = i_tree_data;
                     tree_ok_d = 1'b1;
                  end else begin
                     lat_cnt_d = lat_cnt_q + LAT_W'(1);
                  end
               end
            end
         end

         CMP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; synchronous reset abandons any in-flight check.
   always_ff @(posedge clk) begin
      // NOTE: the vector, accumulator and tree registers are reset like the
      // control flops so that every output reads 0 straight after reset.
      if (rst) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         lat_cnt_q  <= '0;
         tree_q     <= '0;
         tree_ok_q  <= 1'b0;
         sum_ok_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         expected_q <= '0;
         overrun_q  <= 1'b0;
`ifdef ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN
         fe_vec_q   <= '0;
         fe_got_q   <= '0;
         fe_vld_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         lat_cnt_q  <= lat_cnt_d;
         tree_q     <= tree_d;
         tree_ok_q  <= tree_ok_d;
         sum_ok_q   <= sum_ok_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         expected_q <= expected_d;
         overrun_q  <= overrun_d;
`ifdef ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN
         fe_vec_q   <= fe_vec_d;
         fe_got_q   <= fe_got_d;
         fe_vld_q   <= fe_vld_d;
`endif
      end
   end

   sat_counter #(.W(CNT_W)) u_pass_cnt (
      .clk (clk),
      .rst (rst),
      .inc (pass_inc),
      .cnt (o_pass_cnt)
   );

   sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk (clk),
      .rst (rst),
      .inc (fail_inc),
      .cnt (o_fail_cnt)
   );

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_err      = err_q;
   assign o_expected = expected_q;
   assign o_overrun  = overrun_q;
`ifdef ADDER_TREE_CSA_CHECKER_FIRST_ERR_EN
   assign o_first_err_vec = fe_vec_q;
   assign o_first_err_got = fe_got_q;
   assign o_first_err_vld = fe_vld_q;
`endif

endmodule
